// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter for the unified memory port.
// Requester 0 is the core (fetch/load/store); requester 1 is the loader/debug port.
// A locking requester may keep priority for up to LOCK_MAX consecutive grants
// while the other requester waits; then the waiting side gets one grant.
// Grant and memory strobes are registered: the winner chosen in cycle t owns
// the memory port in cycle t+1. mem_rdata is captured on the clock edge that
// closes the read's mem_en cycle, so rvalid/rdata appear the cycle after gnt.
// Optional feature macro: MEM_ARB_PERF_EN adds gnt_cnt0, gnt_cnt1, wait_cnt.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    lock,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   gnt_cnt0,
  output logic [31:0]   gnt_cnt1,
  output logic [31:0]   wait_cnt
`endif
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  logic          state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          lock_held_q, lock_held_d;
  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]    cand;
  logic          lock_active;
  logic          win_valid;
  logic          win;

  // Winner selection: the requester currently on the port is masked out; an
  // active lock holds the port for its owner even if that means an idle cycle.
  always_comb begin
    cand        = req & ~((state_q == STATE_GRANT) ? (sel_q ? 2'b10 : 2'b01) : 2'b00);
    lock_active = lock_held_q && (lock_cnt_q < LOCK_MAX_C);
    win_valid   = 1'b0;
    win         = 1'b0;
    if (lock_active && (req == 2'b11)) begin
      // Holder masked this cycle: leave a gap so it wins again from IDLE.
      if (cand[last_q]) begin
        win_valid = 1'b1;
        win       = last_q;
      end
    end else if (cand == 2'b11) begin
      win_valid = 1'b1;
      win       = ~last_q;
    end else if (cand[0]) begin
      win_valid = 1'b1;
      win       = 1'b0;
    end else if (cand[1]) begin
      win_valid = 1'b1;
      win       = 1'b1;
    end
  end

  // Next-state: FSM, lock bookkeeping, registered grant and memory command.
  always_comb begin
    state_d     = STATE_IDLE;
    sel_d       = sel_q;
    last_d      = last_q;
    lock_held_d = lock_held_q;
    lock_cnt_d  = lock_cnt_q;
    gnt_d       = 2'b00;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (win_valid) begin
      state_d     = STATE_GRANT;
      sel_d       = win;
      last_d      = win;
      lock_held_d = lock[win];
      if (!lock[win]) begin
        lock_cnt_d = 8'd0;
      end else if (win != last_q) begin
        lock_cnt_d = req[~win] ? 8'd1 : 8'd0;
      end else if (req[~win] && (lock_cnt_q < LOCK_MAX_C)) begin
        lock_cnt_d = lock_cnt_q + 8'd1;
      end
      gnt_d       = win ? 2'b10 : 2'b01;
      mem_en_d    = 1'b1;
      mem_we_d    = we[win];
      mem_addr_d  = win ? addr1 : addr0;
      mem_wdata_d = win ? wdata1 : wdata0;
    end
  end

  // Read response: capture memory data at the end of a read grant cycle.
  always_comb begin
    rvalid_d = gnt_q & {2{~mem_we_q}};
    rdata_d  = (|rvalid_d) ? mem_rdata : rdata_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STATE_IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      lock_held_q <= 1'b0;
      lock_cnt_q  <= 8'd0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      lock_held_q <= lock_held_d;
      lock_cnt_q  <= lock_cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [31:0] gnt_cnt1_q, gnt_cnt1_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // Performance counters: grants per requester and requester-cycles spent waiting.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q + {31'd0, gnt_q[0]};
    gnt_cnt1_d = gnt_cnt1_q + {31'd0, gnt_q[1]};
    wait_cnt_d = wait_cnt_q + {31'd0, req[0] & ~gnt_q[0]} + {31'd0, req[1] & ~gnt_q[1]};
  end

  // Counter registers, cleared by reset and wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0_q <= 32'd0;
      gnt_cnt1_q <= 32'd0;
      wait_cnt_q <= 32'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
  assign wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (LOCK_MAX=3): directed scenarios followed by a
// randomized phase, all checked cycle by cycle against a rule-level model.
// Build with MEM_ARB_PERF_EN defined to also check the performance counters.
module tb_mem_port_arbiter;

  localparam int LMAX = 3;

  logic        clk;
  logic        reset;
  logic [1:0]  req, lock, we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] gnt_cnt0, gnt_cnt1, wait_cnt;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .wait_cnt(wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the port in the coming cycle, follow-up state.
  int          m_cur_g;          // requester on the port in the visible cycle, -1 none
  logic        m_cur_we;
  logic [31:0] m_cur_addr;
  int          m_last;
  int          m_streak;
  bit          m_locked;
  logic [1:0]  exp_gnt, exp_rvalid;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic        exp_en, exp_we;
  bit          exp_after_rst;
  logic [31:0] m_gc0, m_gc1, m_wc;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  e0, e1, keep;
    if (reset) begin
      m_cur_g = -1; m_last = 1; m_streak = 0; m_locked = 0;
      exp_gnt = 0; exp_rvalid = 0; exp_rdata = 0; exp_en = 0; exp_we = 0;
      exp_addr = 0; exp_wdata = 0; exp_after_rst = 1;
      m_gc0 = 0; m_gc1 = 0; m_wc = 0;
      return;
    end
    exp_after_rst = 0;
    if (m_cur_g == 0) m_gc0 = m_gc0 + 32'd1;
    if (m_cur_g == 1) m_gc1 = m_gc1 + 32'd1;
    if (req[0] && m_cur_g != 0) m_wc = m_wc + 32'd1;
    if (req[1] && m_cur_g != 1) m_wc = m_wc + 32'd1;
    exp_rvalid = 2'b00;
    if (m_cur_g >= 0 && !m_cur_we) begin
      exp_rvalid[m_cur_g] = 1'b1;
      exp_rdata = memval(m_cur_addr);
    end
    e0 = req[0] && (m_cur_g != 0);
    e1 = req[1] && (m_cur_g != 1);
    keep = m_locked && (m_streak < LMAX) && (req == 2'b11);
    if (keep) nxt = ((m_last == 0) ? e0 : e1) ? m_last : -1;
    else if (e0 && e1) nxt = 1 - m_last;
    else if (e0) nxt = 0;
    else if (e1) nxt = 1;
    else nxt = -1;
    if (nxt >= 0) begin
      if (!lock[nxt]) m_streak = 0;
      else if (nxt != m_last) m_streak = req[1-nxt] ? 1 : 0;
      else if (req[1-nxt] && m_streak < LMAX) m_streak = m_streak + 1;
      m_locked   = lock[nxt];
      m_last     = nxt;
      m_cur_we   = we[nxt];
      m_cur_addr = (nxt == 0) ? addr0 : addr1;
      exp_gnt    = (nxt == 0) ? 2'b01 : 2'b10;
      exp_en     = 1;
      exp_we     = we[nxt];
      exp_addr   = m_cur_addr;
      exp_wdata  = (nxt == 0) ? wdata0 : wdata1;
    end else begin
      exp_gnt = 0; exp_en = 0; exp_we = 0;
    end
    m_cur_g = nxt;
  endtask

  task automatic check_all();
    chk("gnt", {30'd0, gnt}, {30'd0, exp_gnt});
    chk("rvalid", {30'd0, rvalid}, {30'd0, exp_rvalid});
    chk("rdata", rdata, exp_rdata);
    chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_en || exp_after_rst) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, exp_wdata);
    end
`ifdef MEM_ARB_PERF_EN
    chk("gnt_cnt0", gnt_cnt0, m_gc0);
    chk("gnt_cnt1", gnt_cnt1, m_gc1);
    chk("wait_cnt", wait_cnt, m_wc);
`endif
  endtask

  // One clock: memory answers the visible access, model advances, outputs checked.
  task automatic tick();
    mem_rdata = (m_cur_g >= 0 && !m_cur_we) ? memval(m_cur_addr) : $urandom();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1; req = 0; lock = 0; we = 0;
    tick();
    reset = 0;
  endtask

  logic [1:0] t3_tab [14];
  bit         act [2];
  int         idx;

  initial begin
    m_cur_g = -1; m_cur_we = 0; m_cur_addr = 0;
    reset = 1; req = 0; lock = 0; we = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 0;
    @(negedge clk);
    do_reset();
    chk("reset_gnt", {30'd0, gnt}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);

    // Single read
    req = 2'b01; we = 2'b00; addr0 = 32'h100;
    tick();
    $display("t1 read issue: gnt=%b mem_addr=%h", gnt, mem_addr);
    chk("t1_gnt", {30'd0, gnt}, 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    req = 2'b00;
    tick();
    $display("t1 read return: rvalid=%b rdata=%h", rvalid, rdata);
    chk("t1_rvalid", {30'd0, rvalid}, 32'd1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);

    // Contention without lock: strict alternation, plus counters after 10 grants
    do_reset();
    req = 2'b11; lock = 2'b00; we = 2'b11; addr0 = 32'h10; addr1 = 32'h20;
    for (int k = 1; k <= 11; k++) begin
      tick();
      $display("t2 cycle %0d: gnt=%b", k, gnt);
      if (k <= 10) chk("t2_alt", {30'd0, gnt}, (k % 2 == 1) ? 32'd1 : 32'd2);
`ifdef MEM_ARB_PERF_EN
      if (k == 11) begin
        chk("t6_gc0", gnt_cnt0, 32'd5);
        chk("t6_gc1", gnt_cnt1, 32'd5);
      end
`endif
    end

    // Lock with LOCK_MAX=3: requester 1 holds lock, both request continuously
    t3_tab = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01,
               2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 2'b11; lock = 2'b10; we = 2'b00;
    for (int k = 0; k < 14; k++) begin
      tick();
      $display("t3 cycle %0d: gnt=%b", k + 1, gnt);
      chk("t3_lock_seq", {30'd0, gnt}, {30'd0, t3_tab[k]});
    end

    // Write from requester 1
    do_reset();
    req = 2'b10; we = 2'b10; addr1 = 32'h40; wdata1 = 32'h12345678;
    tick();
    $display("t4 write: gnt=%b en=%b we=%b addr=%h wdata=%h", gnt, mem_en, mem_we, mem_addr, mem_wdata);
    chk("t4_gnt", {30'd0, gnt}, 32'd2);
    chk("t4_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t4_addr", mem_addr, 32'h40);
    chk("t4_wdata", mem_wdata, 32'h12345678);
    req = 2'b00;
    tick();
    chk("t4_no_rvalid", {30'd0, rvalid}, 32'd0);

    // Reset during the grant cycle of a read
    do_reset();
    req = 2'b01; we = 2'b00; addr0 = 32'h200;
    tick();
    chk("t5_gnt", {30'd0, gnt}, 32'd1);
    reset = 1; req = 2'b00;
    tick();
    $display("t5 after reset: gnt=%b rvalid=%b en=%b addr=%h rdata=%h", gnt, rvalid, mem_en, mem_addr, rdata);
    chk("t5_rvalid", {30'd0, rvalid}, 32'd0);
    chk("t5_addr", mem_addr, 32'd0);
    chk("t5_en", {31'd0, mem_en}, 32'd0);
    reset = 0; req = 2'b11;
    tick();
    chk("t5_first", {30'd0, gnt}, 32'd1);

    // Randomized traffic with withdrawals, locks and occasional reset
    do_reset();
    act[0] = 0; act[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (act[i] && m_cur_g == i) act[i] = 0;
        else if (act[i] && $urandom_range(39) == 0) act[i] = 0;
        else if (!act[i] && $urandom_range(2) == 0) begin
          act[i]  = 1;
          we[i]   = 1'($urandom_range(1));
          lock[i] = 1'($urandom_range(1));
          if (i == 0) begin addr0 = $urandom(); wdata0 = $urandom(); end
          else begin addr1 = $urandom(); wdata1 = $urandom(); end
        end
        req[i] = act[i];
      end
      reset = ($urandom_range(79) == 0);
      tick();
      if (n % 250 == 0) begin
        idx = n;
        $display("rand %0d: req=%b gnt=%b rvalid=%b", idx, req, gnt, rvalid);
      end
    end

    reset = 0; req = 0;
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
